// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Load/store sequencer and two-port round-robin arbiter in front of a
// single-port data memory. Port 0 is the core LSU, port 1 the program/debug
// loader. One transaction is in flight at a time. Misaligned or illegal
// accesses never touch memory and are answered with an error response.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqN_valid/ready           request handshake per port (ready is combinational)
//   reqN_we/funct3/addr/wdata  store flag, RV32I width code, byte address, store data
//   rspN_valid/rdata/err       one-cycle response pulse, extended load data, error flag
//   mem_addr                   word-aligned memory address (zero-extended to 32 bits)
//   mem_wr                     byte-lane write strobe, nonzero only while writing
//   mem_wdata                  lane-replicated write data
//   mem_rdata                  memory read word, valid RD_LATENCY cycles after address
module dmem_access_ctrl #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [2:0]            req0_funct3,
  input  logic [DM_ADDRESS-1:0] req0_addr,
  input  logic [DATA_W-1:0]     req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [2:0]            req1_funct3,
  input  logic [DM_ADDRESS-1:0] req1_addr,
  input  logic [DATA_W-1:0]     req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_W-1:0]     rsp0_rdata,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  output logic [DATA_W-1:0]     rsp1_rdata,
  output logic                  rsp1_err,
  output logic [31:0]           mem_addr,
  output logic [3:0]            mem_wr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, ERR, RESP} state_t;

  state_t state, state_nxt;

  logic                  last_grant;
  logic                  grant;
  logic                  accept;
  logic                  port_q;
  logic                  err_q;
  logic [1:0]            cnt;

  logic                  sel_we;
  logic [2:0]            sel_f3;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic                  sel_legal;

  logic                  we_q;
  logic [2:0]            f3_q;
  logic [1:0]            lane_q;
  logic signed [DATA_W-1:0] rdata_q;

  // Width/alignment legality. Unsigned widths (100/101) exist only for loads.
  function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = !a[0];
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = !we;
      3'b101:  ok = !we && !a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << a;
      2'b01:   s = 4'b0011 << {a[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Replicate the right-aligned store data across all lanes so the strobe
  // alone selects which bytes land in memory.
  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic signed [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic signed [31:0] r;
    b = word[8*a +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Arbitration: the sole valid port wins; on contention the port that did
  // not win last time wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = !last_grant;
    else if (req1_valid)          grant = 1'b1;
    req0_ready = (state == IDLE) && !grant;
    req1_ready = (state == IDLE) && grant;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  end

  assign sel_we    = grant ? req1_we     : req0_we;
  assign sel_f3    = grant ? req1_funct3 : req0_funct3;
  assign sel_addr  = grant ? req1_addr   : req0_addr;
  assign sel_wdata = grant ? req1_wdata  : req0_wdata;
  assign sel_legal = is_legal(sel_we, sel_f3, sel_addr[1:0]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!sel_legal)  state_nxt = ERR;
          else if (sel_we) state_nxt = WRITE;
          else             state_nxt = READ;
        end
      end
      WRITE:   state_nxt = RESP;
      ERR:     state_nxt = RESP;
      READ:    if (cnt == 2'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, plus the memory address/data outputs which must clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      port_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt        <= 2'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant;
        port_q     <= grant;
        err_q      <= !sel_legal;
        cnt        <= 2'(RD_LATENCY);
        // Illegal accesses leave the memory bus untouched.
        if (sel_legal) begin
          mem_addr <= 32'({sel_addr[DM_ADDRESS-1:2], 2'b00});
          if (sel_we) mem_wdata <= lane_data(sel_f3, sel_wdata);
        end
      end else if (state == READ && cnt != 2'd1) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  // Request fields latched at accept; read data captured on the last READ edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q   <= sel_we;
      f3_q   <= sel_f3;
      lane_q <= sel_addr[1:0];
    end
    if (state == READ && cnt == 2'd1) rdata_q <= extract(f3_q, lane_q, mem_rdata);
  end

  assign mem_wr = (state == WRITE) ? lane_strobe(f3_q, lane_q) : 4'b0000;

  assign rsp0_valid = (state == RESP) && !port_q;
  assign rsp1_valid = (state == RESP) && port_q;
  assign rsp0_err   = rsp0_valid && err_q;
  assign rsp1_err   = rsp1_valid && err_q;
  assign rsp0_rdata = (rsp0_valid && !err_q && !we_q) ? rdata_q : '0;
  assign rsp1_rdata = (rsp1_valid && !err_q && !we_q) ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl (RD_LATENCY = 2).
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [2:0]  req0_funct3 = 3'd0;
  logic [8:0]  req0_addr = 9'd0;
  logic [31:0] req0_wdata = 32'd0;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [2:0]  req1_funct3 = 3'd0;
  logic [8:0]  req1_addr = 9'd0;
  logic [31:0] req1_wdata = 32'd0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wr;
  logic [31:0] mem_rdata = 32'd0;

  int checks = 0;
  int failures = 0;

  dmem_access_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .RD_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_funct3(req0_funct3), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_funct3(req1_funct3), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic we, input logic [2:0] f3,
                       input logic [8:0] a, input logic [31:0] wd);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_funct3 = f3; req0_addr = a; req0_wdata = wd;
    end else begin
      req1_valid = v; req1_we = we; req1_funct3 = f3; req1_addr = a; req1_wdata = wd;
    end
  endtask

  // One complete transaction on port p. Loads respond at accept+3 (RD_LATENCY+1),
  // stores and errors at accept+2.
  task automatic xact(input string tag, input int p, input logic we, input logic [2:0] f3,
                      input logic [8:0] a, input logic [31:0] wd, input logic [31:0] word,
                      input logic [3:0] exp_wr, input logic [31:0] exp_wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    logic [8:0] wa;
    lat = (exp_err || we) ? 2 : 3;
    wa = {a[8:2], 2'b00};
    @(negedge clk);
    drive(p, 1'b1, we, f3, a, wd);
    #1;
    chk({tag, ":ready"}, (p == 0) ? req0_ready : req1_ready, 32'd1);
    @(negedge clk);
    drive(p, 1'b0, 1'b0, 3'd0, 9'd0, 32'd0);
    mem_rdata = word;
    #1;
    chk({tag, ":wr"}, mem_wr, exp_wr);
    if (!exp_err) chk({tag, ":addr"}, mem_addr, 32'(wa));
    if (we && !exp_err) chk({tag, ":wdata"}, mem_wdata, exp_wdata);
    for (int c = 2; c < lat; c++) begin
      @(negedge clk); #1;
      chk({tag, ":early_rsp"}, {rsp0_valid, rsp1_valid}, 32'd0);
      chk({tag, ":wr_idle"}, mem_wr, 32'd0);
    end
    @(negedge clk); #1;
    chk({tag, ":rsp_valid"}, (p == 0) ? rsp0_valid : rsp1_valid, 32'd1);
    chk({tag, ":other_silent"}, (p == 0) ? rsp1_valid : rsp0_valid, 32'd0);
    chk({tag, ":err"}, (p == 0) ? rsp0_err : rsp1_err, 32'(exp_err));
    chk({tag, ":rdata"}, (p == 0) ? rsp0_rdata : rsp1_rdata, exp_rdata);
    chk({tag, ":wr_rsp"}, mem_wr, 32'd0);
  endtask

  initial begin
    int g;
    // Reset state
    #12;
    chk("rst:mem_wr", mem_wr, 32'd0);
    chk("rst:mem_addr", mem_addr, 32'd0);
    chk("rst:mem_wdata", mem_wdata, 32'd0);
    chk("rst:rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset: grants alternate 0,1,0,1 starting with port 0
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 3'b010, 9'h020, 32'd0);
    drive(1, 1'b1, 1'b0, 3'b010, 9'h024, 32'd0);
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      mem_rdata = 32'h1000_0000 + 32'(k);
      #1;
      chk("cont:ready0", req0_ready, 32'(g == 0));
      chk("cont:ready1", req1_ready, 32'(g == 1));
      @(negedge clk); #1;
      chk("cont:addr", mem_addr, (g == 1) ? 32'h024 : 32'h020);
      @(negedge clk); #1;
      chk("cont:early_rsp", {rsp0_valid, rsp1_valid}, 32'd0);
      @(negedge clk); #1;
      chk("cont:rsp_port", {rsp1_valid, rsp0_valid}, (g == 1) ? 32'd2 : 32'd1);
      chk("cont:rdata", (g == 1) ? rsp1_rdata : rsp0_rdata, 32'h1000_0000 + 32'(k));
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 3'd0, 9'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 9'd0, 32'd0);

    // Store word
    xact("sw", 0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'd0, 4'b1111, 32'hDEADBEEF, 32'd0, 1'b0);
    // Byte store and byte loads
    xact("sb", 0, 1'b1, 3'b000, 9'h013, 32'h000000A5, 32'd0, 4'b1000, 32'hA5A5A5A5, 32'd0, 1'b0);
    xact("lb", 1, 1'b0, 3'b000, 9'h013, 32'd0, 32'hA5000000, 4'b0000, 32'd0, 32'hFFFFFFA5, 1'b0);
    xact("lbu", 0, 1'b0, 3'b100, 9'h013, 32'd0, 32'hA5000000, 4'b0000, 32'd0, 32'h000000A5, 1'b0);
    // Halfword store and loads
    xact("sh", 1, 1'b1, 3'b001, 9'h012, 32'h1234BEEF, 32'd0, 4'b1100, 32'hBEEFBEEF, 32'd0, 1'b0);
    xact("lh_hi", 0, 1'b0, 3'b001, 9'h012, 32'd0, 32'h80011234, 4'b0000, 32'd0, 32'hFFFF8001, 1'b0);
    xact("lhu_hi", 1, 1'b0, 3'b101, 9'h012, 32'd0, 32'h80011234, 4'b0000, 32'd0, 32'h00008001, 1'b0);
    xact("lh_lo", 0, 1'b0, 3'b001, 9'h010, 32'd0, 32'h80011234, 4'b0000, 32'd0, 32'h00001234, 1'b0);
    // Illegal accesses
    xact("lw_mis", 0, 1'b0, 3'b010, 9'h006, 32'd0, 32'hFFFFFFFF, 4'b0000, 32'd0, 32'd0, 1'b1);
    xact("sh_mis", 1, 1'b1, 3'b001, 9'h001, 32'h0000FFFF, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b1);
    xact("ld_f3_011", 0, 1'b0, 3'b011, 9'h000, 32'd0, 32'hFFFFFFFF, 4'b0000, 32'd0, 32'd0, 1'b1);
    xact("st_f3_100", 1, 1'b1, 3'b100, 9'h000, 32'h12345678, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b1);

    // Reset during WRITE (port 0 is then last_grant, so port 1 would win without reset)
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 3'b010, 9'h030, 32'h11223344);
    #1;
    chk("rstw:ready", req0_ready, 32'd1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 3'd0, 9'd0, 32'd0);
    #1;
    chk("rstw:wr_before", mem_wr, 32'hF);
    rst_n = 1'b0;
    #1;
    chk("rstw:wr_now", mem_wr, 32'd0);
    chk("rstw:addr", mem_addr, 32'd0);
    chk("rstw:rsp_now", {rsp0_valid, rsp1_valid}, 32'd0);
    @(negedge clk); #1;
    chk("rstw:rsp_held", {rsp0_valid, rsp1_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rstw:rsp_after", {rsp0_valid, rsp1_valid}, 32'd0);
    chk("rstw:wr_after", mem_wr, 32'd0);
    drive(0, 1'b1, 1'b0, 3'b010, 9'h000, 32'd0);
    drive(1, 1'b1, 1'b0, 3'b010, 9'h004, 32'd0);
    #1;
    chk("rstw:grant0", req0_ready, 32'd1);
    chk("rstw:grant1", req1_ready, 32'd0);
    drive(0, 1'b0, 1'b0, 3'd0, 9'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 9'd0, 32'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
